// File: rtl/shift_adsr_env_if.sv
// Bus bundle for the shift-based ADSR envelope: note control, rates, sample in/out and status.
// master drives note/rate/sample inputs; slave is the envelope generator.
interface shift_adsr_env_if #(
    parameter int unsigned WL     = 16,
    parameter int unsigned SW     = 5,
    parameter int unsigned RATE_W = 8
);
    logic                     GATE;
    logic                     TRIG;
    logic signed [WL-1:0]     data_in;
    logic        [RATE_W-1:0] ATK_RATE;
    logic        [RATE_W-1:0] DEC_RATE;
    logic        [RATE_W-1:0] REL_RATE;
    logic        [SW-1:0]     SUS_LVL;
    logic signed [WL-1:0]     data_out;
    logic        [SW-1:0]     total;
    logic        [2:0]        state;
    logic                     hold;
    logic                     z_flg;
    logic                     rel_done;

    modport master (
        output GATE, TRIG, data_in, ATK_RATE, DEC_RATE, REL_RATE, SUS_LVL,
        input  data_out, total, state, hold, z_flg, rel_done
    );

    modport slave (
        input  GATE, TRIG, data_in, ATK_RATE, DEC_RATE, REL_RATE, SUS_LVL,
        output data_out, total, state, hold, z_flg, rel_done
    );
endinterface

// File: rtl/shift_adsr_env.sv
// Shift-based ADSR envelope: scales a signed sample by arithmetic right shift of (WL - total),
// with per-phase rate prescalers, retrigger from release and a hard zero at total=0.
module shift_adsr_env #(
    parameter int unsigned WL     = 16,
    parameter int unsigned SW     = 5,
    parameter int unsigned RATE_W = 8
) (
    input logic             CLK,
    input logic             RST_N,
    shift_adsr_env_if.slave bus
);
    localparam logic [SW-1:0] WL_T = SW'(WL);
    localparam logic [SW:0]   WL_X = (SW+1)'(WL);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic        [SW-1:0]     total_q, total_d;
    logic        [RATE_W-1:0] cnt_q, cnt_d;
    logic signed [WL-1:0]     data_out_q, data_out_d;
    logic                     hold_q, hold_d;
    logic                     z_flg_q, z_flg_d;
    logic                     rel_done_q, rel_done_d;

    logic        [RATE_W-1:0] rate_c;
    logic                     step_c;
    logic        [SW-1:0]     sus_c;
    logic        [SW:0]       shamt_c;

    // Rate of the phase currently being timed; IDLE/SUSTAIN do not count.
    always_comb begin
        rate_c = '0;
        case (state_q)
            ATTACK:  rate_c = bus.ATK_RATE;
            DECAY:   rate_c = bus.DEC_RATE;
            RELEASE: rate_c = bus.REL_RATE;
            default: rate_c = '0;
        endcase
    end

    assign step_c = (cnt_q == rate_c);
    assign sus_c  = (bus.SUS_LVL > WL_T) ? WL_T : bus.SUS_LVL;

    // Next-state and envelope position; GATE low wins over any step in the active phases.
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        cnt_d      = '0;
        z_flg_d    = z_flg_q;
        rel_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                total_d = '0;
                z_flg_d = 1'b0;
                if (bus.GATE && bus.TRIG) state_d = ATTACK;
            end
            ATTACK: begin
                if (!bus.GATE) begin
                    state_d = RELEASE;
                end else if (step_c) begin
                    if (total_q < WL_T) begin
                        total_d = total_q + SW'(1);
                    end else begin
                        state_d = DECAY;
                        z_flg_d = 1'b1;
                    end
                end
            end
            DECAY: begin
                if (!bus.GATE) begin
                    state_d = RELEASE;
                end else if (step_c) begin
                    if (total_q > sus_c) total_d = total_q - SW'(1);
                    else                 state_d = SUSTAIN;
                end
            end
            SUSTAIN: begin
                if (!bus.GATE) state_d = RELEASE;
            end
            RELEASE: begin
                if (bus.GATE && bus.TRIG) begin
                    state_d = ATTACK;
                    z_flg_d = 1'b0;
                end else if (step_c) begin
                    if (total_q != '0) begin
                        total_d = total_q - SW'(1);
                    end else begin
                        state_d    = IDLE;
                        z_flg_d    = 1'b0;
                        rel_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                total_d = '0;
                z_flg_d = 1'b0;
            end
        endcase
        // Prescaler restarts on any transition; the transition edge never steps.
        if ((state_d == state_q) && (state_q inside {ATTACK, DECAY, RELEASE})) begin
            cnt_d = step_c ? '0 : cnt_q + RATE_W'(1);
        end
        hold_d = (state_d != IDLE);
    end

    // Output scaling uses the pre-update total, giving one cycle of latency.
    always_comb begin
        shamt_c = WL_X - {1'b0, total_q};
        if (total_q == '0) data_out_d = '0;
        else               data_out_d = bus.data_in >>> shamt_c;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            total_q    <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            hold_q     <= 1'b0;
            z_flg_q    <= 1'b0;
            rel_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            hold_q     <= hold_d;
            z_flg_q    <= z_flg_d;
            rel_done_q <= rel_done_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.total    = total_q;
    assign bus.data_out = data_out_q;
    assign bus.hold     = hold_q;
    assign bus.z_flg    = z_flg_q;
    assign bus.rel_done = rel_done_q;
endmodule

// File: tb/tb_shift_adsr_env.sv
// Scoreboard bench for shift_adsr_env: per-edge expected status is queued with the stimulus and popped per edge.
module tb_shift_adsr_env;
    localparam int unsigned WL     = 16;
    localparam int unsigned SW     = 5;
    localparam int unsigned RATE_W = 8;

    logic CLK;
    logic RST_N;
    int   checks = 0;
    int   errors = 0;

    shift_adsr_env_if #(.WL(WL), .SW(SW), .RATE_W(RATE_W)) bus ();

    shift_adsr_env #(.WL(WL), .SW(SW), .RATE_W(RATE_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  st;
        logic [4:0]  tot;
        logic        z;
        logic        hold;
        logic        rd;
        logic [15:0] dout;
        logic        chk;
    } exp_t;

    exp_t sb[$];

    function automatic void push(input int st, input int t, input logic z, input logic hold,
                                 input logic rd, input logic [15:0] dout, input logic chk);
        exp_t x;
        x.st = 3'(st); x.tot = 5'(t); x.z = z; x.hold = hold; x.rd = rd; x.dout = dout; x.chk = chk;
        sb.push_back(x);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus.GATE = 1'b0; bus.TRIG = 1'b1; bus.data_in = 16'sh4000;
        bus.ATK_RATE = '0; bus.DEC_RATE = '0; bus.REL_RATE = '0; bus.SUS_LVL = 5'd12;
        #12;
        checks++;
        if ({bus.state, bus.total, bus.hold, bus.z_flg, bus.rel_done, bus.data_out} !== 27'd0) begin
            errors++;
            $display("FAIL reset: st=%0d tot=%0d hold=%b z=%b rd=%b dout=%h want all zero",
                     bus.state, bus.total, bus.hold, bus.z_flg, bus.rel_done, bus.data_out);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.state !== 3'd0 || bus.hold !== 1'b0) begin
                errors++;
                $display("FAIL idle_trig_no_gate: st=%0d hold=%b want st=0 hold=0", bus.state, bus.hold);
            end
        end
    endtask

    task automatic test_attack_decay();
        exp_t x;
        int st, t, ptot;
        logic z;
        bus.ATK_RATE = 8'd0; bus.DEC_RATE = 8'd0; bus.SUS_LVL = 5'd12; bus.data_in = 16'sh4000;
        bus.GATE = 1'b1; bus.TRIG = 1'b1;
        ptot = 0; z = 1'b0;
        for (int e = 1; e <= 23; e++) begin
            if (e == 1)       begin st = 1; t = 0; end
            else if (e <= 17) begin st = 1; t = e - 1; end
            else if (e == 18) begin st = 2; t = 16; z = 1'b1; end
            else if (e <= 22) begin st = 2; t = 34 - e; end
            else              begin st = 3; t = 12; end
            // 0x4000 shifted by (16 - t) is 2^(t-2), and zero below t=2
            push(st, t, z, 1'b1, 1'b0, (ptot < 2) ? 16'h0 : 16'(1 << (ptot - 2)), 1'b1);
            ptot = t;
        end
        for (int e = 1; e <= 23; e++) begin
            tick();
            x = sb.pop_front();
            checks++;
            if ({bus.state, bus.total, bus.z_flg, bus.hold, bus.rel_done} !== {x.st, x.tot, x.z, x.hold, x.rd}) begin
                errors++;
                $display("FAIL attack_decay e%0d: st/tot/z/hold/rd got %0d/%0d/%b/%b/%b want %0d/%0d/%b/%b/%b", e,
                         bus.state, bus.total, bus.z_flg, bus.hold, bus.rel_done, x.st, x.tot, x.z, x.hold, x.rd);
            end
            if (x.chk) begin
                checks++;
                if (bus.data_out !== x.dout) begin
                    errors++;
                    $display("FAIL datapath_pos e%0d: dout got %h want %h", e, bus.data_out, x.dout);
                end
            end
        end
    endtask

    task automatic test_sustain_hold();
        bus.SUS_LVL = 5'd3;
        for (int i = 0; i < 4; i++) begin
            bus.TRIG = i[0];
            tick();
            checks++;
            if (bus.state !== 3'd3 || bus.total !== 5'd12) begin
                errors++;
                $display("FAIL sustain_frozen: st=%0d tot=%0d want st=3 tot=12", bus.state, bus.total);
            end
        end
    endtask

    task automatic test_release();
        exp_t x;
        bus.REL_RATE = 8'd1; bus.GATE = 1'b0; bus.TRIG = 1'b0;
        for (int e = 1; e <= 28; e++)
            push((e < 27) ? 4 : 0, (e <= 25) ? 12 - (e - 1) / 2 : 0, (e < 27), (e < 27), (e == 27), 16'h0, 1'b0);
        for (int e = 1; e <= 28; e++) begin
            tick();
            x = sb.pop_front();
            checks++;
            if ({bus.state, bus.total, bus.z_flg, bus.hold, bus.rel_done} !== {x.st, x.tot, x.z, x.hold, x.rd}) begin
                errors++;
                $display("FAIL release e%0d: st/tot/z/hold/rd got %0d/%0d/%b/%b/%b want %0d/%0d/%b/%b/%b", e,
                         bus.state, bus.total, bus.z_flg, bus.hold, bus.rel_done, x.st, x.tot, x.z, x.hold, x.rd);
            end
        end
    endtask

    task automatic test_datapath_neg();
        int n;
        bus.data_in = 16'sh8000; bus.ATK_RATE = 8'd0; bus.GATE = 1'b1; bus.TRIG = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.total !== 5'd1 || bus.data_out !== 16'sh0000) begin
            errors++;
            $display("FAIL datapath_zero: tot=%0d dout=%h want tot=1 dout=0000", bus.total, bus.data_out);
        end
        tick();
        checks++;
        if (bus.data_out !== 16'shFFFF) begin
            errors++;
            $display("FAIL datapath_neg: dout got %h want ffff", bus.data_out);
        end
        bus.GATE = 1'b0; bus.TRIG = 1'b0; bus.REL_RATE = 8'd0;
        n = 0;
        while (bus.state !== 3'd0 && n < 50) begin tick(); n++; end
        checks++;
        if (bus.state !== 3'd0) begin
            errors++;
            $display("FAIL idle_timeout: st=%0d want 0 within 50 edges", bus.state);
        end
    endtask

    task automatic test_prescaler_clamp();
        exp_t x;
        bus.ATK_RATE = 8'd3; bus.DEC_RATE = 8'd0; bus.SUS_LVL = 5'd31; bus.GATE = 1'b1; bus.TRIG = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            if (e <= 68)      push(1, (e - 1) / 4, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
            else if (e == 69) push(2, 16, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
            else              push(3, 16, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        end
        for (int e = 1; e <= 70; e++) begin
            tick();
            x = sb.pop_front();
            checks++;
            if ({bus.state, bus.total, bus.z_flg, bus.hold, bus.rel_done} !== {x.st, x.tot, x.z, x.hold, x.rd}) begin
                errors++;
                $display("FAIL prescaler_clamp e%0d: st/tot/z/hold/rd got %0d/%0d/%b/%b/%b want %0d/%0d/%b/%b/%b", e,
                         bus.state, bus.total, bus.z_flg, bus.hold, bus.rel_done, x.st, x.tot, x.z, x.hold, x.rd);
            end
        end
    endtask

    task automatic test_retrigger_gate_peak();
        exp_t x;
        bus.REL_RATE = 8'd0; bus.ATK_RATE = 8'd0; bus.GATE = 1'b0; bus.TRIG = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            if (e <= 10)      push(4, 17 - e, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
            else if (e == 11) push(1, 7, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
            else if (e <= 20) push(1, e - 4, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
            else              push(4, 37 - e, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        end
        for (int e = 1; e <= 22; e++) begin
            tick();
            x = sb.pop_front();
            checks++;
            if ({bus.state, bus.total, bus.z_flg, bus.hold, bus.rel_done} !== {x.st, x.tot, x.z, x.hold, x.rd}) begin
                errors++;
                $display("FAIL retrig_peak e%0d: st/tot/z/hold/rd got %0d/%0d/%b/%b/%b want %0d/%0d/%b/%b/%b", e,
                         bus.state, bus.total, bus.z_flg, bus.hold, bus.rel_done, x.st, x.tot, x.z, x.hold, x.rd);
            end
            if (e == 10) begin bus.GATE = 1'b1; bus.TRIG = 1'b1; end
            if (e == 20) begin bus.GATE = 1'b0; bus.TRIG = 1'b0; end
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (bus.state !== 3'd0 && n < 50) begin tick(); n++; end
        bus.ATK_RATE = 8'd0; bus.GATE = 1'b1; bus.TRIG = 1'b1; bus.data_in = 16'sh4000;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus.state !== 3'd1 || bus.total !== 5'd9) begin
            errors++;
            $display("FAIL pre_reset: st=%0d tot=%0d want st=1 tot=9", bus.state, bus.total);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({bus.state, bus.total, bus.hold, bus.z_flg, bus.rel_done, bus.data_out} !== 27'd0) begin
            errors++;
            $display("FAIL async_reset: st=%0d tot=%0d hold=%b z=%b rd=%b dout=%h want all zero",
                     bus.state, bus.total, bus.hold, bus.z_flg, bus.rel_done, bus.data_out);
        end
        #10 RST_N = 1'b1;
    endtask

    initial begin
        test_reset();
        test_attack_decay();
        test_sustain_hold();
        test_release();
        test_datapath_neg();
        test_prescaler_clamp();
        test_retrigger_gate_peak();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_adsr_env.md
Name: shift_adsr_env

Overview:
- Parametrised shift-based ADSR envelope generator: successor to the fixed 16-bit attack/decay shifter.
- Scales a signed sample stream by arithmetic right shift; shift amount is WL − total, with total ∈ [0, WL].
- Adds explicit ATTACK/DECAY/SUSTAIN/RELEASE states, per-phase rate prescalers, retrigger from release, and a clean zero output at total=0.
- Sits between the waveform ROM and the mixer; hold feeds the frequency controller enable.

Parameters:
- WL, 16, sample word length; also the maximum total.
- SW, 5, width of total and SUS_LVL; must satisfy 2^SW > WL.
- RATE_W, 8, width of the rate prescaler and rate inputs.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- GATE  in  1  master enable (note held); low forces release.
- TRIG  in  1  note-on request; only qualified with GATE.
- data_in  in  WL signed  sample from ROM.
- ATK_RATE  in  RATE_W  attack step period − 1.
- DEC_RATE  in  RATE_W  decay step period − 1.
- REL_RATE  in  RATE_W  release step period − 1.
- SUS_LVL  in  SW  sustain total; values above WL are clamped to WL.
- data_out  out  WL signed  registered shifted sample.
- total  out  SW  current envelope position.
- state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- hold  out  1  high in every state except IDLE.
- z_flg  out  1  set when attack peak is reached; cleared on IDLE entry or retrigger.
- rel_done  out  1  one-cycle pulse on the RELEASE→IDLE transition.

Behaviour:
- RST_N low (async): state=IDLE; total=0; data_out=0; hold=0; z_flg=0; rel_done=0; prescaler=0.
- **Prescaler**
  - Counts 0..R, where R is the rate input of the current state.
  - A step occurs on the edge where the count equals R; the count then returns to 0.
  - R=0 gives a step on every edge.
  - The prescaler clears on every state transition. The transition edge itself never steps.
- **GATE low priority:** GATE low overrides all other conditions. From ATTACK, DECAY or SUSTAIN, the next edge enters RELEASE.
- **IDLE**
  - total=0, hold=0.
  - GATE&TRIG → ATTACK; hold=1 on the same edge.
- **ATTACK** (step on ATK_RATE)
  - Step with total<WL: total+1.
  - Step with total==WL: → DECAY, z_flg=1.
- **DECAY** (step on DEC_RATE; S = min(SUS_LVL, WL))
  - Step with total>S: total−1.
  - Step with total≤S: → SUSTAIN, total unchanged.
- **SUSTAIN**
  - total frozen; SUS_LVL changes are ignored until the next note.
  - TRIG is ignored.
- **RELEASE** (step on REL_RATE)
  - Step with total>0: total−1.
  - Step with total==0: → IDLE; hold=0, z_flg=0, rel_done=1 for one cycle.
  - GATE&TRIG in RELEASE → ATTACK from the current total, z_flg=0. Retrigger has priority over the release step.
- TRIG in ATTACK or DECAY is ignored (no restart).
- **Output datapath**
  - data_out <= (total==0) ? 0 : data_in >>> (WL − total).
  - Uses the total value before this edge's update, giving one-cycle latency from data_in.
  - Sign-extending shift; shift widths are computed at SW+1 bits with no wrap.
- total never leaves [0, WL]. Unused state encodings 5–7 recover to IDLE on the next edge.

Test Plan:
- Reset, sample, output zero:
  - Stimulus: RST_N low mid-ATTACK with total=9.
  - Response: total, hold, z_flg, data_out and state go to 0 immediately, without waiting for a clock edge.
- Attack ramp and peak:
  - Stimulus: WL=16, ATK_RATE=0, DEC_RATE=0, SUS_LVL=12, GATE=TRIG=1 from IDLE.
  - Response: edge1 → ATTACK, total=0; edges 2–17 give total 1..16; edge18 → DECAY with z_flg=1; edges 19–22 give total 15..12; edge23 → SUSTAIN with total=12.
- Datapath:
  - data_in=16'sh4000: total=16 → 16'sh4000; total=15 → 16'sh2000.
  - data_in=16'sh8000: total=1 → 16'shFFFF; total=0 → 16'sh0000.
- Rate prescaler:
  - Stimulus: ATK_RATE=3.
  - Response: total increments exactly once every 4 edges; 64 edges after ATTACK entry total=16.
- Release, done pulse, clamp:
  - Stimulus: from SUSTAIN with total=12, REL_RATE=1, drop GATE.
  - Response: → RELEASE; total decrements every 2 edges; reaches 0, then one more step gives IDLE with rel_done high for exactly 1 cycle and hold=0.
  - Separately, SUS_LVL=31 goes from DECAY straight to SUSTAIN at total=16.
- Retrigger and simultaneity:
  - Stimulus: in RELEASE at total=7, assert GATE&TRIG.
  - Response: → ATTACK with total=7 and z_flg=0.
  - Stimulus: GATE falls on the same edge as the attack peak.
  - Response: → RELEASE, not DECAY.
